// File: rtl/cpu_pkg.sv
// cpu_pkg: SimpleCPU widths and opcode encodings shared by fetch and the control decoder
package cpu_pkg;
  localparam int XLEN_DEF = 32;
  localparam int INST_W = 32;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  function automatic logic [6:0] opcode_of(input logic [INST_W-1:0] inst);
    return inst[6:0];
  endfunction
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: imem request/response, branch redirect and decode handshake around fetch
interface instr_fetch_if #(parameter int XLEN = cpu_pkg::XLEN_DEF);
  logic imem_req_valid;
  logic imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic imem_resp_valid;
  logic [cpu_pkg::INST_W-1:0] imem_resp_data;
  logic redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic inst_valid;
  logic inst_ready;
  logic [cpu_pkg::INST_W-1:0] inst_data;
  logic [XLEN-1:0] inst_pc;
  logic [6:0] inst_opcode;
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_opcode,
    input imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, inst_ready
  );
  modport slave (
    input imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, inst_opcode,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; dout reads zero while empty
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic flush,
  input logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic empty,
  output logic full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= din;
  no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !flush));
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, issues credit-limited in-order imem requests, buffers words for decode.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushed counters.
module instr_fetch import cpu_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  instr_fetch_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] pc_q, tag_pc;
  logic [CW-1:0] out_cnt, drop_cnt, occ;
  logic [INST_W+XLEN-1:0] head;
  logic req_fire, deq, dropping, push_inst;
  logic tag_empty, tag_full, iq_empty, iq_full;
  assign bus.imem_req_valid = ({1'b0, out_cnt} + {1'b0, occ} < (CW+1)'(DEPTH)) && !bus.redirect_valid;
  assign bus.imem_req_addr = pc_q;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign dropping = drop_cnt != '0 || bus.redirect_valid;
  assign push_inst = bus.imem_resp_valid && !dropping;
  assign deq = bus.inst_valid && bus.inst_ready;
  assign bus.inst_valid = !iq_empty;
  assign bus.inst_data = head[INST_W+XLEN-1:XLEN];
  assign bus.inst_pc = head[XLEN-1:0];
  assign bus.inst_opcode = opcode_of(bus.inst_data);
  // the tag FIFO occupancy is the outstanding-request count, stale ones included
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tags (
    .clk(clk), .rst(rst), .push(req_fire), .pop(bus.imem_resp_valid), .flush(1'b0),
    .din(pc_q), .dout(tag_pc), .empty(tag_empty), .full(tag_full), .count(out_cnt)
  );
  fetch_fifo #(.WIDTH(INST_W + XLEN), .DEPTH(DEPTH)) u_insts (
    .clk(clk), .rst(rst), .push(push_inst), .pop(bus.inst_ready), .flush(bus.redirect_valid),
    .din({bus.imem_resp_data, tag_pc}), .dout(head), .empty(iq_empty), .full(iq_full), .count(occ)
  );
  // on redirect every outstanding request still unanswered this cycle becomes stale
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q <= RESET_PC;
      drop_cnt <= '0;
    end else if (bus.redirect_valid) begin
      pc_q <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      drop_cnt <= out_cnt - CW'(bus.imem_resp_valid);
    end else begin
      if (req_fire) pc_q <= pc_q + XLEN'(4);
      if (bus.imem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
    end
  no_orphan_resp: assert property (@(posedge clk) disable iff (rst) !(bus.imem_resp_valid && tag_empty));
  no_tag_overflow: assert property (@(posedge clk) disable iff (rst) !(req_fire && tag_full));
  no_inst_overflow: assert property (@(posedge clk) disable iff (rst) !(push_inst && iq_full && !deq));
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(deq);
      perf_flushed <= perf_flushed + 32'(bus.imem_resp_valid && dropping)
                    + (bus.redirect_valid ? 32'(occ) - 32'(deq) : 32'd0);
    end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized fetch traffic checked against a queue-level reference model
module tb_instr_fetch;
  localparam int DEPTH = 4;
  typedef struct { logic [31:0] pc; bit stale; } tag_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  instr_fetch_if #(.XLEN(32)) bus();
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif
  instr_fetch #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );
  tag_t m_out[$];
  logic [63:0] m_iq[$];
  mreq_t mq[$];
  logic [31:0] m_pc, m_fetched, m_flushed, redir_pc, s_addr, s_pc;
  logic [6:0] s_op;
  int cyc, last_due, lat_min, lat_max, rr_pct, ir_pct, rd_pct, checks, failures;
  bit redir_now, addi_only, s_fire, s_iv, s_resp, s_rv;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return addi_only ? 32'h0000_0013 : (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction
  function automatic bit roll(input int p);
    return int'($urandom_range(99)) < p;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic step();
    bit exp_rv, fire, rv, resp;
    logic [31:0] rpc;
    tag_t t;
    int lat;
    @(negedge clk);
    bus.imem_req_ready = roll(rr_pct);
    bus.inst_ready = roll(ir_pct);
    rv = redir_now || roll(rd_pct);
    rpc = redir_now ? redir_pc : $urandom;
    redir_now = 1'b0;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    resp = mq.size() != 0 && mq[0].due <= cyc;
    bus.imem_resp_valid = resp;
    bus.imem_resp_data = resp ? mem_word(mq[0].addr) : $urandom;
    #1;
    exp_rv = (m_out.size() + m_iq.size() < DEPTH) && !rv;
    chk("req_valid", bus.imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
    chk("inst_valid", bus.inst_valid, m_iq.size() != 0);
    if (m_iq.size() != 0) begin
      chk("inst_data", bus.inst_data, m_iq[0][63:32]);
      chk("inst_pc", bus.inst_pc, m_iq[0][31:0]);
      chk("inst_opcode", bus.inst_opcode, m_iq[0][38:32]);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_flushed", perf_flushed, m_flushed);
`endif
    s_rv = bus.imem_req_valid;
    s_fire = bus.imem_req_valid && bus.imem_req_ready;
    s_addr = bus.imem_req_addr;
    s_iv = bus.inst_valid;
    s_pc = bus.inst_pc;
    s_op = bus.inst_opcode;
    s_resp = resp;
    @(posedge clk);
    if (resp) void'(mq.pop_front());
    if (s_fire) begin
      lat = int'($urandom_range(lat_max, lat_min));
      last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mq.push_back('{s_addr, last_due});
    end
    fire = exp_rv && bus.imem_req_ready;
    if (m_iq.size() != 0 && bus.inst_ready) begin
      void'(m_iq.pop_front());
      m_fetched++;
    end
    if (resp && m_out.size() != 0) begin
      t = m_out.pop_front();
      if (t.stale || rv) m_flushed++;
      else m_iq.push_back({bus.imem_resp_data, t.pc});
    end
    if (rv) begin
      m_flushed += 32'(m_iq.size());
      m_iq.delete();
      foreach (m_out[i]) m_out[i].stale = 1'b1;
      m_pc = rpc & ~32'h3;
    end else if (fire) begin
      m_out.push_back('{m_pc, 1'b0});
      m_pc += 32'd4;
    end
    cyc++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0;
    #1;
    chk("rst_inst_valid", bus.inst_valid, 1'b0);
    chk("rst_inst_data", bus.inst_data, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    chk("rst_inst_opcode", bus.inst_opcode, 7'h0);
    m_out.delete();
    m_iq.delete();
    mq.delete();
    m_pc = 32'h0;
    m_fetched = '0;
    m_flushed = '0;
    cyc = 0;
    last_due = 0;
    @(negedge clk);
    #1 chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    for (int k = 0; k < 20; k++) begin
      step();
      if (s_iv) break;
    end
    chk(name, {s_iv, s_pc}, {1'b1, exp_pc});
  endtask
  initial begin
    int n;
    checks = 0;
    failures = 0;
    redir_now = 1'b0;
    addi_only = 1'b1;
    lat_min = 1; lat_max = 1; rr_pct = 100; ir_pct = 100; rd_pct = 0;
    do_reset();
    step(); chk("t1_req0", {s_fire, s_addr}, {1'b1, 32'h0}); chk("t1_iv0", s_iv, 1'b0);
    step(); chk("t1_req1", {s_fire, s_addr}, {1'b1, 32'h4}); chk("t1_iv1", s_iv, 1'b0);
    step(); chk("t1_req2", {s_fire, s_addr}, {1'b1, 32'h8});
    chk("t1_inst0", {s_iv, s_pc, s_op}, {1'b1, 32'h0, 7'b0010011});
    step(); chk("t1_inst1", {s_iv, s_pc, s_op}, {1'b1, 32'h4, 7'b0010011});
    step(); chk("t1_inst2", {s_iv, s_pc, s_op}, {1'b1, 32'h8, 7'b0010011});
    do_reset();
    ir_pct = 0;
    n = 0;
    repeat (10) begin
      step();
      n += int'(s_fire);
    end
    chk("t2_credits", n, 4);
    chk("t2_req_low", s_rv, 1'b0);
    chk("t2_head", {s_iv, s_pc}, {1'b1, 32'h0});
    ir_pct = 100;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_order", {s_iv, s_pc}, {1'b1, 32'(i * 4)});
    end
    do_reset();
    lat_min = 3; lat_max = 3;
    step(); step();
    redir_now = 1'b1; redir_pc = 32'h100;
    step(); chk("t3_redir_req_low", s_rv, 1'b0);
    step(); chk("t3_target", {s_fire, s_addr}, {1'b1, 32'h100});
    wait_valid("t3_first_pc", 32'h100);
    do_reset();
    lat_min = 1; lat_max = 1;
    step(); step();
    redir_now = 1'b1; redir_pc = 32'h103;
    step();
    chk("t4_consumed", {s_iv, s_pc}, {1'b1, 32'h0});
    chk("t4_resp", s_resp, 1'b1);
    step(); chk("t4_target", {s_fire, s_addr}, {1'b1, 32'h100});
    wait_valid("t4_first_pc", 32'h100);
    do_reset();
    redir_now = 1'b1; redir_pc = 32'hFFFF_FFFE;
    step();
    step(); chk("t5_top", {s_fire, s_addr}, {1'b1, 32'hFFFF_FFFC});
    step(); chk("t5_wrap", {s_fire, s_addr}, {1'b1, 32'h0});
    do_reset();
    lat_min = 3; lat_max = 3; ir_pct = 0;
    repeat (5) step();
    do_reset();
    ir_pct = 100;
    step(); chk("t6_restart", {s_fire, s_addr}, {1'b1, 32'h0});
    wait_valid("t6_first_pc", 32'h0);
    addi_only = 1'b0;
    for (int ph = 0; ph < 8; ph++) begin
      do_reset();
      lat_min = int'($urandom_range(2, 1));
      lat_max = lat_min + int'($urandom_range(5));
      rr_pct = int'($urandom_range(100, 30));
      ir_pct = int'($urandom_range(100, 20));
      rd_pct = int'($urandom_range(20));
      repeat (3000) step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
